sys_word2byte: RTL

SYS_WORD2BYTE -- requirements
Module: sys_word2byte

---
 rtl/sys_pkg_stream.sv | 31 +++
 rtl/sys_pkg_type.sv | 11 +
 rtl/sys_skid_buf.sv | 61 ++++++
 rtl/sys_word2byte.sv | 129 ++++++++++++
 4 files changed

// File: rtl/sys_pkg_stream.sv
`default_nettype none
// ============================================================================
// Package : sys_pkg_stream -- byte-stream helpers (keep-mask select, width check)
// Rev     : 1.0
// ============================================================================
package sys_pkg_stream;

   localparam int c_max_bytes = 8;

   function automatic bit word_bytes_ok(input int n);
      return (n >= 2) && (n <= c_max_bytes);
   endfunction

   // Index of the next byte to emit: lowest set bit, or highest when msb_first.
   function automatic int keep_sel(input logic [c_max_bytes-1:0] mask, input logic msb_first);
      int sel;
      sel = 0;
      if (msb_first) begin
         for (int i = 0; i < c_max_bytes; i++) begin
            if (mask[i]) sel = i;
         end
      end else begin
         for (int i = c_max_bytes - 1; i >= 0; i--) begin
            if (mask[i]) sel = i;
         end
      end
      return sel;
   endfunction

endpackage : sys_pkg_stream
`default_nettype wire

// File: rtl/sys_pkg_type.sv
`default_nettype none
// ============================================================================
// Package : sys_pkg_type -- scalar types shared across the sys_* blocks
// Rev     : 1.0
// ============================================================================
package sys_pkg_type;

   typedef logic [7:0] u8;

endpackage : sys_pkg_type
`default_nettype wire

// File: rtl/sys_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : sys_skid_buf -- one-word skid buffer, registered valid and ready
// Rev    : 1.0
// ============================================================================
module sys_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   logic             r_out_valid;
   logic             r_skid_valid;
   logic             r_ready;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] r_skid_data;
   logic             w_in_fire;
   logic             w_skid_nxt;

   assign w_in_fire  = i_valid & r_ready;
   // The skid slot fills only when a word arrives while the output is stalled.
   assign w_skid_nxt = r_skid_valid ? ~i_ready : (w_in_fire & r_out_valid & ~i_ready);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_ready      <= 1'b0;
         r_out_data   <= '0;
         r_skid_data  <= '0;
      end else begin
         r_skid_valid <= w_skid_nxt;
         r_ready      <= ~w_skid_nxt;
         if (r_skid_valid) begin
            if (i_ready) r_out_data <= r_skid_data;
         end else if (w_in_fire) begin
            if (r_out_valid && !i_ready) begin
               r_skid_data <= i_data;
            end else begin
               r_out_data  <= i_data;
               r_out_valid <= 1'b1;
            end
         end else if (i_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_out_valid;
   assign o_data  = r_out_data;

endmodule : sys_skid_buf
`default_nettype wire

// File: rtl/sys_word2byte.sv
`default_nettype none
// ============================================================================
// Module : sys_word2byte -- keep-qualified word to byte-stream serializer;
//          SYS_WORD2BYTE_SKID_EN adds an input skid stage for gapless words
// Rev    : 1.0
// ============================================================================
module sys_word2byte
   import sys_pkg_type::*;
   import sys_pkg_stream::*;
#(
   parameter int WORD_BYTES = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [8*WORD_BYTES-1:0] i_data,
   input  logic [WORD_BYTES-1:0]   i_keep,
   input  logic                    i_last,
   output logic                    o_valid,
   input  logic                    i_ready,
   output u8                       o_data,
   output logic                    o_last
);

   localparam int         c_idx_w    = $clog2(WORD_BYTES);
   localparam logic [0:0] c_st_idle  = 1'b0;
   localparam logic [0:0] c_st_shift = 1'b1;

   if (!word_bytes_ok(WORD_BYTES)) begin : g_bad_width
      $error("sys_word2byte: WORD_BYTES must be in 2..8");
   end

   logic                    w_in_valid;
   logic [8*WORD_BYTES-1:0] w_in_data;
   logic [WORD_BYTES-1:0]   w_in_keep;
   logic                    w_in_last;
   logic                    w_core_ready;

`ifdef SYS_WORD2BYTE_SKID_EN
   localparam int c_pay_w = 8*WORD_BYTES + WORD_BYTES + 1;
   logic [c_pay_w-1:0] w_skid_out;

   sys_skid_buf #(
      .WIDTH (c_pay_w)
   ) u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  ({i_last, i_keep, i_data}),
      .o_valid (w_in_valid),
      .i_ready (w_core_ready),
      .o_data  (w_skid_out)
   );

   assign {w_in_last, w_in_keep, w_in_data} = w_skid_out;
`else
   assign w_in_valid = i_valid;
   assign w_in_data  = i_data;
   assign w_in_keep  = i_keep;
   assign w_in_last  = i_last;
   assign o_ready    = w_core_ready;
`endif

   logic [0:0]                  r_state;
   logic [0:0]                  w_state_nxt;
   logic [WORD_BYTES-1:0][7:0]  r_data;
   logic [WORD_BYTES-1:0]       r_keep;
   logic                        r_last;
   logic                        r_ready_en;
   logic [c_idx_w-1:0]          w_sel;
   logic [WORD_BYTES-1:0]       w_sel_oh;
   logic [WORD_BYTES-1:0]       w_keep_left;
   logic                        w_final;
   logic                        w_out_fire;
   logic                        w_load;

   assign w_sel       = c_idx_w'(keep_sel(8'(r_keep), BIG_ENDIAN));
   assign w_sel_oh    = WORD_BYTES'(1) << w_sel;
   assign w_keep_left = r_keep & ~w_sel_oh;
   assign w_final     = (w_keep_left == '0);
   assign w_out_fire  = o_valid & i_ready;

   // Ready never looks at the input valid; r_ready_en holds it low for the reset edge.
   assign w_core_ready = r_ready_en & ((r_state == c_st_idle) | (w_out_fire & w_final));
   assign w_load       = w_in_valid & w_core_ready & (|w_in_keep);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= c_st_idle;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (w_load) w_state_nxt = c_st_shift;
         c_st_shift: if (w_out_fire && w_final && !w_load) w_state_nxt = c_st_idle;
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_data     <= '0;
         r_keep     <= '0;
         r_last     <= 1'b0;
         r_ready_en <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_load) begin
            r_data <= w_in_data;
            r_keep <= w_in_keep;
            r_last <= w_in_last;
         end else if (w_out_fire) begin
            r_keep <= w_keep_left;
         end
      end
   end

   always_comb begin
      o_valid = (r_state == c_st_shift);
      o_data  = r_data[w_sel];
      o_last  = (r_state == c_st_shift) & r_last & w_final;
   end

endmodule : sys_word2byte
`default_nettype wire
